// File: rtl/lsq_issue_feed.sv
// In-order load/store queue feeding the LS issue unit. Holds store data until it
// arrives on the CDB and presents the head entry through a ready/accept handshake.
module lsq_issue_feed #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               dispatch_en,
  input  logic               dispatch_opcode,
  input  logic [31:0]        dispatch_address,
  input  logic [5:0]         dispatch_tag,
  input  logic [31:0]        dispatch_data,
  input  logic               dispatch_data_valid,
  input  logic [5:0]         dispatch_data_tag,
  input  logic               cdb_valid,
  input  logic [5:0]         cdb_tag,
  input  logic [31:0]        cdb_data,
  input  logic               ls_ready_in,
  output logic               ls_ready_out,
  output logic [31:0]        ls_data,
  output logic [31:0]        ls_address,
  output logic [5:0]         ls_tag,
  output logic               ls_opcode,
  output logic               lsq_full,
  output logic [PTR_W:0]     lsq_count
);

  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_opcode;
  logic [DEPTH-1:0] r_dv;
  logic [31:0]      r_addr  [DEPTH];
  logic [5:0]       r_tag   [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic [5:0]       r_dtag  [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_new_dv;
  logic [31:0]      w_new_data;
  logic [DEPTH-1:0] w_snoop;

  assign w_full       = (r_count == LP_FULL);
  assign ls_ready_out = r_valid[r_head] && r_dv[r_head];
  assign ls_data      = r_data[r_head];
  assign ls_address   = r_addr[r_head];
  assign ls_tag       = r_tag[r_head];
  assign ls_opcode    = r_opcode[r_head];
  assign lsq_full     = w_full;
  assign lsq_count    = r_count;

  assign w_push = dispatch_en && !w_full;
  assign w_pop  = ls_ready_out && ls_ready_in;

  // Loads never wait on data; a pending store can still catch a same-cycle CDB broadcast.
  always_comb begin
    w_new_dv   = 1'b1;
    w_new_data = dispatch_data;
    if (dispatch_opcode && !dispatch_data_valid) begin
      if (cdb_valid && (cdb_tag == dispatch_data_tag)) begin
        w_new_data = cdb_data;
      end else begin
        w_new_dv = 1'b0;
      end
    end
  end

  always_comb begin
    w_snoop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_snoop[i] = cdb_valid && r_valid[i] && !r_dv[i] && (r_dtag[i] == cdb_tag);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_opcode <= '0;
      r_dv     <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_tag[i]  <= '0;
        r_data[i] <= '0;
        r_dtag[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_snoop[i]) begin
          r_data[i] <= cdb_data;
          r_dv[i]   <= 1'b1;
        end
      end
      // The tail slot is always empty when a push is accepted, so it never collides with a snoop.
      if (w_push) begin
        r_valid[r_tail]  <= 1'b1;
        r_opcode[r_tail] <= dispatch_opcode;
        r_addr[r_tail]   <= dispatch_address;
        r_tag[r_tail]    <= dispatch_tag;
        r_dtag[r_tail]   <= dispatch_data_tag;
        r_data[r_tail]   <= w_new_data;
        r_dv[r_tail]     <= w_new_dv;
        r_tail           <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsq_issue_feed.sv
// Directed bench for lsq_issue_feed: in-order issue, store data wakeup, full/drop,
// same-cycle capture, flush priority and asynchronous reset.
module tb_lsq_issue_feed;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        dispatch_en;
  logic        dispatch_opcode;
  logic [31:0] dispatch_address;
  logic [5:0]  dispatch_tag;
  logic [31:0] dispatch_data;
  logic        dispatch_data_valid;
  logic [5:0]  dispatch_data_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ls_ready_in;
  logic        ls_ready_out;
  logic [31:0] ls_data;
  logic [31:0] ls_address;
  logic [5:0]  ls_tag;
  logic        ls_opcode;
  logic        lsq_full;
  logic [3:0]  lsq_count;

  int checks = 0;
  int errors = 0;

  lsq_issue_feed #(.DEPTH(8), .PTR_W(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .dispatch_en         (dispatch_en),
    .dispatch_opcode     (dispatch_opcode),
    .dispatch_address    (dispatch_address),
    .dispatch_tag        (dispatch_tag),
    .dispatch_data       (dispatch_data),
    .dispatch_data_valid (dispatch_data_valid),
    .dispatch_data_tag   (dispatch_data_tag),
    .cdb_valid           (cdb_valid),
    .cdb_tag             (cdb_tag),
    .cdb_data            (cdb_data),
    .ls_ready_in         (ls_ready_in),
    .ls_ready_out        (ls_ready_out),
    .ls_data             (ls_data),
    .ls_address          (ls_address),
    .ls_tag              (ls_tag),
    .ls_opcode           (ls_opcode),
    .lsq_full            (lsq_full),
    .lsq_count           (lsq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic op, input logic [31:0] addr, input logic [5:0] tag,
                      input logic dv, input logic [5:0] dtag, input logic [31:0] data);
    dispatch_en         = 1'b1;
    dispatch_opcode     = op;
    dispatch_address    = addr;
    dispatch_tag        = tag;
    dispatch_data_valid = dv;
    dispatch_data_tag   = dtag;
    dispatch_data       = data;
  endtask

  task automatic idle();
    dispatch_en         = 1'b0;
    dispatch_opcode     = 1'b0;
    dispatch_address    = 32'h0;
    dispatch_tag        = 6'h0;
    dispatch_data_valid = 1'b0;
    dispatch_data_tag   = 6'h0;
    dispatch_data       = 32'h0;
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    cdb_valid   = 1'b0;
    cdb_tag     = 6'h0;
    cdb_data    = 32'h0;
    ls_ready_in = 1'b0;
    idle();
    #12;
    chk("rst_ready",  32'(ls_ready_out), 32'd0);
    chk("rst_count",  32'(lsq_count),    32'd0);
    chk("rst_full",   32'(lsq_full),     32'd0);
    chk("rst_addr",   ls_address,        32'd0);
    chk("rst_tag",    32'(ls_tag),       32'd0);
    reset = 1'b0;

    // three loads issued back to back
    ls_ready_in = 1'b1;
    push(1'b0, 32'h100, 6'd1, 1'b0, 6'd0, 32'h0);
    tick();
    chk("l1_ready", 32'(ls_ready_out), 32'd1);
    chk("l1_addr",  ls_address,        32'h100);
    chk("l1_tag",   32'(ls_tag),       32'd1);
    chk("l1_op",    32'(ls_opcode),    32'd0);
    chk("l1_count", 32'(lsq_count),    32'd1);
    push(1'b0, 32'h104, 6'd2, 1'b0, 6'd0, 32'h0);
    tick();
    chk("l2_addr",  ls_address,        32'h104);
    chk("l2_tag",   32'(ls_tag),       32'd2);
    chk("l2_count", 32'(lsq_count),    32'd1);
    push(1'b0, 32'h108, 6'd3, 1'b0, 6'd0, 32'h0);
    tick();
    chk("l3_addr",  ls_address,        32'h108);
    chk("l3_tag",   32'(ls_tag),       32'd3);
    idle();
    tick();
    chk("l_empty_count", 32'(lsq_count),    32'd0);
    chk("l_empty_ready", 32'(ls_ready_out), 32'd0);

    // store waits for tag 9 and blocks the younger load
    push(1'b1, 32'h200, 6'd10, 1'b0, 6'd9, 32'h0);
    tick();
    chk("st_wait_ready", 32'(ls_ready_out), 32'd0);
    chk("st_wait_count", 32'(lsq_count),    32'd1);
    push(1'b0, 32'h204, 6'd4, 1'b0, 6'd0, 32'h0);
    tick();
    chk("st_block_ready", 32'(ls_ready_out), 32'd0);
    chk("st_block_count", 32'(lsq_count),    32'd2);
    chk("st_block_tag",   32'(ls_tag),       32'd10);
    idle();
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEADBEEF;
    tick();
    cdb_valid = 1'b0;
    chk("st_wake_ready", 32'(ls_ready_out), 32'd1);
    chk("st_wake_data",  ls_data,           32'hDEADBEEF);
    chk("st_wake_op",    32'(ls_opcode),    32'd1);
    chk("st_wake_addr",  ls_address,        32'h200);
    tick();
    chk("ld_after_tag",   32'(ls_tag),       32'd4);
    chk("ld_after_ready", 32'(ls_ready_out), 32'd1);
    chk("ld_after_count", 32'(lsq_count),    32'd1);
    tick();
    chk("st_drain_count", 32'(lsq_count), 32'd0);

    // fill to full with pointers starting mid-buffer
    ls_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 32'h300 + 32'(i * 4), 6'(i), 1'b0, 6'd0, 32'h0);
      tick();
    end
    chk("full_flag",  32'(lsq_full),  32'd1);
    chk("full_count", 32'(lsq_count), 32'd8);
    chk("full_head",  32'(ls_tag),    32'd0);
    push(1'b0, 32'h3FC, 6'h3F, 1'b0, 6'd0, 32'h0);
    tick();
    chk("drop_count", 32'(lsq_count), 32'd8);
    chk("drop_head",  32'(ls_tag),    32'd0);
    // dispatch while full is dropped even with a same-cycle pop
    ls_ready_in = 1'b1;
    tick();
    chk("drop_pop_count", 32'(lsq_count), 32'd7);
    chk("drop_pop_full",  32'(lsq_full),  32'd0);
    idle();
    for (int i = 1; i < 8; i++) begin
      chk("drain_tag",   32'(ls_tag),       32'(i));
      chk("drain_addr",  ls_address,        32'h300 + 32'(i * 4));
      chk("drain_ready", 32'(ls_ready_out), 32'd1);
      tick();
    end
    chk("drain_end_count", 32'(lsq_count),    32'd0);
    chk("drain_end_ready", 32'(ls_ready_out), 32'd0);
    ls_ready_in = 1'b0;
    push(1'b0, 32'h380, 6'h20, 1'b0, 6'd0, 32'h0);
    tick();
    push(1'b0, 32'h384, 6'h21, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    chk("refill_count", 32'(lsq_count), 32'd2);
    chk("refill_tag0",  32'(ls_tag),    32'h20);
    ls_ready_in = 1'b1;
    tick();
    chk("refill_tag1",  32'(ls_tag),    32'h21);
    chk("refill_addr1", ls_address,     32'h384);
    tick();
    chk("refill_empty", 32'(lsq_count), 32'd0);

    // same-cycle capture, then one CDB wakes two stores
    ls_ready_in = 1'b0;
    push(1'b1, 32'h400, 6'd11, 1'b0, 6'd5, 32'h0);
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h12345678;
    tick();
    cdb_valid = 1'b0;
    chk("cap_ready", 32'(ls_ready_out), 32'd1);
    chk("cap_data",  ls_data,           32'h12345678);
    push(1'b1, 32'h404, 6'd12, 1'b0, 6'd7, 32'h0);
    tick();
    push(1'b1, 32'h408, 6'd13, 1'b0, 6'd7, 32'h0);
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hA5A5A5A5;
    tick();
    cdb_valid = 1'b0;
    chk("multi_count", 32'(lsq_count), 32'd3);
    ls_ready_in = 1'b1;
    chk("multi_head_data", ls_data, 32'h12345678);
    tick();
    chk("multi_s1_tag",   32'(ls_tag),       32'd12);
    chk("multi_s1_ready", 32'(ls_ready_out), 32'd1);
    chk("multi_s1_data",  ls_data,           32'hA5A5A5A5);
    tick();
    chk("multi_s2_tag",   32'(ls_tag),       32'd13);
    chk("multi_s2_ready", 32'(ls_ready_out), 32'd1);
    chk("multi_s2_data",  ls_data,           32'hA5A5A5A5);
    tick();
    chk("multi_empty", 32'(lsq_count), 32'd0);

    // flush wins over a simultaneous push and pop
    ls_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 32'h500 + 32'(i * 4), 6'(20 + i), 1'b0, 6'd0, 32'h0);
      tick();
    end
    chk("pre_flush_count", 32'(lsq_count), 32'd4);
    flush = 1'b1;
    ls_ready_in = 1'b1;
    push(1'b0, 32'h5F0, 6'h30, 1'b0, 6'd0, 32'h0);
    tick();
    flush = 1'b0;
    idle();
    chk("flush_count", 32'(lsq_count),    32'd0);
    chk("flush_ready", 32'(ls_ready_out), 32'd0);
    tick();
    chk("flush_stay_count", 32'(lsq_count),    32'd0);
    chk("flush_stay_ready", 32'(ls_ready_out), 32'd0);
    push(1'b0, 32'h5F4, 6'h31, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    chk("post_flush_tag",   32'(ls_tag),       32'h31);
    chk("post_flush_ready", 32'(ls_ready_out), 32'd1);
    chk("post_flush_count", 32'(lsq_count),    32'd1);
    tick();
    chk("post_flush_empty", 32'(lsq_count), 32'd0);

    // asynchronous reset in the middle of a cycle with 5 entries held
    ls_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 32'h600 + 32'(i * 4), 6'(40 + i), 1'b0, 6'd0, 32'h0);
      tick();
    end
    idle();
    chk("pre_rst_count", 32'(lsq_count), 32'd5);
    chk("pre_rst_tag",   32'(ls_tag),    32'd40);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(lsq_count),    32'd0);
    chk("arst_ready", 32'(ls_ready_out), 32'd0);
    chk("arst_full",  32'(lsq_full),     32'd0);
    chk("arst_addr",  ls_address,        32'd0);
    chk("arst_tag",   32'(ls_tag),       32'd0);
    @(negedge clk);
    reset = 1'b0;
    push(1'b0, 32'h700, 6'd45, 1'b0, 6'd0, 32'h0);
    tick();
    idle();
    chk("after_rst_ready", 32'(ls_ready_out), 32'd1);
    chk("after_rst_tag",   32'(ls_tag),       32'd45);
    chk("after_rst_addr",  ls_address,        32'h700);
    chk("after_rst_count", 32'(lsq_count),    32'd1);
    ls_ready_in = 1'b1;
    tick();
    chk("after_rst_empty", 32'(lsq_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
